// File: rtl/cpu_dbus_arb.sv
// rtl/cpu_dbus_arb.sv - round-robin arbiter of N CPU data-bus masters onto one DBIU port
// Two-state FSM: IDLE picks a requester, BUSY forwards it until ack, timeout or request drop.
module cpu_dbus_arb #(
    parameter int N_CPU   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CPU-1:0]    req_m2a,
    input  logic [N_CPU*AW-1:0] adr_m2a,
    input  logic [N_CPU*DW-1:0] dat_m2a,
    input  logic [N_CPU-1:0]    we_m2a,
    input  logic [N_CPU*SW-1:0] sel_m2a,
    output logic [DW-1:0]       dat_a2m,
    output logic [N_CPU-1:0]    ack_a2m,
    output logic [N_CPU-1:0]    err_a2m,
    output logic                req_m2dbiu,
    output logic [AW-1:0]       adr_m2dbiu,
    output logic [DW-1:0]       dat_m2dbiu,
    output logic                we_m2dbiu,
    output logic [SW-1:0]       sel_m2dbiu,
    input  logic [DW-1:0]       dat_dbiu2m,
    input  logic                ack_dbiu2m
);

    localparam int GW = (N_CPU > 1) ? $clog2(N_CPU) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [GW-1:0] G_LAST   = GW'(N_CPU - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [GW-1:0]    g;
    logic [GW-1:0]    rr_ptr;
    logic [CW-1:0]    cnt;

    logic [GW-1:0]    pick;
    logic [GW-1:0]    cand;
    logic             found;
    logic [GW-1:0]    g_next;
    logic [N_CPU-1:0] g_onehot;

    logic             sel_req;
    logic [AW-1:0]    sel_adr;
    logic [DW-1:0]    sel_dat;
    logic             sel_we;
    logic [SW-1:0]    sel_sel;

    logic             busy;
    logic             busy_live;
    logic             ack_fire;
    logic             to_fire;

    // First requester at or after rr_ptr, wrapping modulo N_CPU.
    always_comb begin
        pick  = rr_ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CPU; k++) begin
            cand = GW'((int'(rr_ptr) + k) % N_CPU);
            if (!found && req_m2a[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_req = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        sel_we  = 1'b0;
        sel_sel = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (g == GW'(i)) begin
                sel_req = req_m2a[i];
                sel_adr = adr_m2a[i*AW +: AW];
                sel_dat = dat_m2a[i*DW +: DW];
                sel_we  = we_m2a[i];
                sel_sel = sel_m2a[i*SW +: SW];
            end
        end
    end

    assign g_onehot  = N_CPU'(1) << g;
    assign g_next    = (g == G_LAST) ? '0 : g + GW'(1);

    // A dropped request masks everything, including a stray downstream ack.
    assign busy      = (state == BUSY);
    assign busy_live = busy && sel_req;
    assign ack_fire  = busy_live && ack_dbiu2m;
    assign to_fire   = busy_live && !ack_dbiu2m && (TIMEOUT != 0) && (cnt == CNT_LAST);

    assign req_m2dbiu = busy_live;
    assign adr_m2dbiu = busy ? sel_adr : '0;
    assign dat_m2dbiu = busy ? sel_dat : '0;
    assign we_m2dbiu  = busy ? sel_we  : 1'b0;
    assign sel_m2dbiu = busy ? sel_sel : '0;

    assign ack_a2m = (ack_fire || to_fire) ? g_onehot : '0;
    assign err_a2m = to_fire ? g_onehot : '0;
    assign dat_a2m = ack_fire ? dat_dbiu2m : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_m2a) begin
                        g     <= pick;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_req) begin
                        state <= IDLE;
                    end else if (ack_fire || to_fire) begin
                        state  <= IDLE;
                        rr_ptr <= g_next;
                    end else if (TIMEOUT != 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dbus_arb.sv
// tb/tb_cpu_dbus_arb.sv - scoreboard bench for cpu_dbus_arb with N_CPU=2, TIMEOUT=4
module tb_cpu_dbus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_m2a;
    logic [63:0] adr_m2a;
    logic [63:0] dat_m2a;
    logic [1:0]  we_m2a;
    logic [7:0]  sel_m2a;
    logic [31:0] dat_a2m;
    logic [1:0]  ack_a2m;
    logic [1:0]  err_a2m;
    logic        req_m2dbiu;
    logic [31:0] adr_m2dbiu;
    logic [31:0] dat_m2dbiu;
    logic        we_m2dbiu;
    logic [3:0]  sel_m2dbiu;
    logic [31:0] dat_dbiu2m;
    logic        ack_dbiu2m;

    cpu_dbus_arb #(
        .N_CPU(2), .AW(32), .DW(32), .SW(4), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_m2a(req_m2a), .adr_m2a(adr_m2a), .dat_m2a(dat_m2a),
        .we_m2a(we_m2a), .sel_m2a(sel_m2a),
        .dat_a2m(dat_a2m), .ack_a2m(ack_a2m), .err_a2m(err_a2m),
        .req_m2dbiu(req_m2dbiu), .adr_m2dbiu(adr_m2dbiu), .dat_m2dbiu(dat_m2dbiu),
        .we_m2dbiu(we_m2dbiu), .sel_m2dbiu(sel_m2dbiu),
        .dat_dbiu2m(dat_dbiu2m), .ack_dbiu2m(ack_dbiu2m)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cpu;
        bit          err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input int cpu, input bit err, input logic [31:0] dat);
        exp_t x;
        x.cpu = cpu;
        x.err = err;
        x.dat = dat;
        sb.push_back(x);
    endtask

    // Monitor: every acknowledge must match the oldest expected response.
    always @(negedge clk) begin
        if (ack_a2m != 2'b00 || err_a2m != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'({ack_a2m, err_a2m}), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("ack_vec", 64'(ack_a2m), 64'(2'b01 << e.cpu));
                chk("err_vec", 64'(err_a2m), e.err ? 64'(2'b01 << e.cpu) : 64'(0));
                chk("ack_dat", 64'(dat_a2m), 64'(e.dat));
            end
        end else begin
            chk("idle_dat", 64'(dat_a2m), 64'(0));
        end
    end

    initial begin
        rst_n      = 1'b1;
        req_m2a    = 2'b00;
        adr_m2a    = {32'h0000_0200, 32'h0000_0100};
        dat_m2a    = {32'h2222_2222, 32'h1111_1111};
        we_m2a     = 2'b10;
        sel_m2a    = {4'h3, 4'hF};
        dat_dbiu2m = 32'h0;
        ack_dbiu2m = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", 64'(req_m2dbiu), 64'(0));
        chk("rst_adr", 64'(adr_m2dbiu), 64'(0));
        chk("rst_ack", 64'(ack_a2m), 64'(0));
        chk("rst_err", 64'(err_a2m), 64'(0));
        chk("rst_dat", 64'(dat_a2m), 64'(0));
        step();
        rst_n = 1'b1;

        // Single read from CPU 0, ack on the third BUSY cycle.
        step();
        req_m2a = 2'b01;
        step();
        @(negedge clk);
        chk("t1_req_dbiu", 64'(req_m2dbiu), 64'(1));
        chk("t1_adr_dbiu", 64'(adr_m2dbiu), 64'h100);
        step();
        step();
        expect_ack(0, 1'b0, 32'h0000_CAFE);
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h0000_CAFE;
        step();
        ack_dbiu2m = 1'b0;
        req_m2a    = 2'b00;
        @(negedge clk);
        chk("t1_idle_req", 64'(req_m2dbiu), 64'(0));

        // Both CPUs requesting continuously; rr_ptr is 1 after the previous grant.
        step();
        req_m2a = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int exp_cpu;
            exp_cpu = (i % 2 == 0) ? 1 : 0;
            step();
            expect_ack(exp_cpu, 1'b0, 32'hA0 + 32'(i));
            ack_dbiu2m = 1'b1;
            dat_dbiu2m = 32'hA0 + 32'(i);
            @(negedge clk);
            chk("t2_adr", 64'(adr_m2dbiu), (exp_cpu == 1) ? 64'h200 : 64'h100);
            chk("t2_we", 64'(we_m2dbiu), (exp_cpu == 1) ? 64'(1) : 64'(0));
            chk("t2_sel", 64'(sel_m2dbiu), (exp_cpu == 1) ? 64'h3 : 64'hF);
            step();
            ack_dbiu2m = 1'b0;
            if (i == 3) req_m2a = 2'b00;
        end

        // Timeout: no downstream ack, error on the fourth BUSY cycle.
        step();
        req_m2a = 2'b01;
        step();
        dat_dbiu2m = 32'hDEAD_BEEF;
        step();
        step();
        step();
        expect_ack(0, 1'b1, 32'h0);
        @(negedge clk);
        chk("t3_req_held", 64'(req_m2dbiu), 64'(1));
        step();
        req_m2a = 2'b00;
        @(negedge clk);
        chk("t3_req_drop", 64'(req_m2dbiu), 64'(0));

        // Ack coincident with the timeout cycle wins.
        step();
        req_m2a = 2'b10;
        step();
        step();
        step();
        step();
        expect_ack(1, 1'b0, 32'h0000_1234);
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h0000_1234;
        step();
        ack_dbiu2m = 1'b0;
        req_m2a    = 2'b00;

        // Stray downstream ack while IDLE.
        step();
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h5555_5555;
        @(negedge clk);
        chk("t5_no_ack", 64'(ack_a2m), 64'(0));
        step();
        ack_dbiu2m = 1'b0;
        @(negedge clk);
        chk("t5_still_idle", 64'(req_m2dbiu), 64'(0));

        // Move rr_ptr to 1, then reset in the middle of a CPU 1 transaction.
        step();
        req_m2a = 2'b01;
        step();
        expect_ack(0, 1'b0, 32'h77);
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h77;
        step();
        ack_dbiu2m = 1'b0;
        req_m2a    = 2'b11;
        step();
        @(negedge clk);
        chk("t6_pre_grant", 64'(adr_m2dbiu), 64'h200);
        step();
        #2 rst_n = 1'b0;
        ack_dbiu2m = 1'b1;
        #1;
        chk("t6_rst_req", 64'(req_m2dbiu), 64'(0));
        chk("t6_rst_adr", 64'(adr_m2dbiu), 64'(0));
        chk("t6_rst_ack", 64'(ack_a2m), 64'(0));
        chk("t6_rst_err", 64'(err_a2m), 64'(0));
        step();
        ack_dbiu2m = 1'b0;
        rst_n      = 1'b1;
        step();
        expect_ack(0, 1'b0, 32'h88);
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h88;
        @(negedge clk);
        chk("t6_post_grant", 64'(adr_m2dbiu), 64'h100);
        step();
        ack_dbiu2m = 1'b0;
        req_m2a    = 2'b10;
        step();
        @(negedge clk);
        chk("t6_cpu1_grant", 64'(adr_m2dbiu), 64'h200);

        // Request withdrawn mid-transaction: no ack, rr_ptr unchanged.
        step();
        req_m2a = 2'b00;
        @(negedge clk);
        chk("t7_req_drop", 64'(req_m2dbiu), 64'(0));
        step();
        req_m2a = 2'b11;
        step();
        expect_ack(1, 1'b0, 32'h99);
        ack_dbiu2m = 1'b1;
        dat_dbiu2m = 32'h99;
        @(negedge clk);
        chk("t7_rr_kept", 64'(adr_m2dbiu), 64'h200);
        step();
        ack_dbiu2m = 1'b0;
        req_m2a    = 2'b00;
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_dbus_arb.md
CPU_DBUS_ARB -- requirements
Module: cpu_dbus_arb

Interface
REQ-001 Parameter N_CPU, default 2, number of CPU request ports (1..8).
REQ-002 Parameter AW, default DBUS_AW, address width.
REQ-003 Parameter DW, default DBUS_DW, data width.
REQ-004 Parameter SW, default DBUS_ISEL, byte-select width.
REQ-005 Parameter TIMEOUT, default 256, maximum cycles waiting for downstream ack; 0 disables the timeout.
REQ-006 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 req_m2a  in  N_CPU  per-CPU request, held high until acked.
REQ-010 adr_m2a  in  N_CPU*AW  packed per-CPU address, slice i = CPU i.
REQ-011 dat_m2a  in  N_CPU*DW  packed per-CPU write data.
REQ-012 we_m2a  in  N_CPU  per-CPU write enable.
REQ-013 sel_m2a  in  N_CPU*SW  packed per-CPU byte selects.
REQ-014 dat_a2m  out  DW  read data, shared, valid with the ack of the granted CPU.
REQ-015 ack_a2m  out  N_CPU  per-CPU one-cycle acknowledge.
REQ-016 err_a2m  out  N_CPU  per-CPU one-cycle error flag, only asserted together with ack_a2m.
REQ-017 req_m2dbiu, adr_m2dbiu[AW], dat_m2dbiu[DW], we_m2dbiu, sel_m2dbiu[SW]  out  downstream request to DBIU.
REQ-018 dat_dbiu2m  in  DW  downstream read data.
REQ-019 ack_dbiu2m  in  1  downstream one-cycle acknowledge.

Function
REQ-020 FSM states: IDLE, BUSY.
REQ-021 IDLE: if any req_m2a bit is set, the block shall register grant index g, chosen round-robin starting at rr_ptr, and go to BUSY next cycle.
REQ-022 Round-robin: search order rr_ptr, rr_ptr+1, ... modulo N_CPU; rr_ptr shall be set to (g+1) mod N_CPU when a transaction completes.
REQ-023 BUSY: req_m2dbiu shall equal req_m2a[g]; adr/dat/we/sel_m2dbiu shall be driven from slice g combinationally.
REQ-024 IDLE: req_m2dbiu=0; adr/dat/we/sel_m2dbiu=0.
REQ-025 BUSY with ack_dbiu2m=1: ack_a2m[g]=1 and dat_a2m=dat_dbiu2m in the same cycle (combinational); FSM returns to IDLE next cycle.
REQ-026 Latency: request seen in IDLE at cycle t -> req_m2dbiu at t+1; ack pass-through is zero-cycle; one IDLE bubble after every completion.
REQ-027 ack_dbiu2m in IDLE shall be ignored: no ack_a2m, no state change.
REQ-028 Timeout: a counter shall clear on entry to BUSY and increment each BUSY cycle without ack; when the count reaches TIMEOUT-1 with no ack, the block shall assert ack_a2m[g]=1, err_a2m[g]=1, dat_a2m=0 for that cycle, and return to IDLE.
REQ-029 An ack_dbiu2m in the same cycle as the timeout shall take priority: normal ack, err_a2m=0.
REQ-030 If req_m2a[g] drops in BUSY before ack (protocol violation), the block shall return to IDLE next cycle without ack_a2m and without advancing rr_ptr.
REQ-031 ack_a2m and err_a2m bits other than g shall be 0 at all times; dat_a2m=0 when no ack_a2m bit is set.
REQ-032 Counter width shall be $clog2(TIMEOUT+1); no wrap is possible because the counter stops at TIMEOUT-1.

Reset
REQ-033 While rst_n=0: FSM=IDLE, rr_ptr=0, g=0, counter=0, all outputs 0, asynchronously.
REQ-034 Reset asserted mid-transaction shall abort it with no ack_a2m; the first grant after release follows rr_ptr=0.

Verification
REQ-035 N_CPU=2, req_m2a=01, adr=0x100, ack_dbiu2m 3 cycles after grant with dat=0xCAFE -> req_m2dbiu at t+1, adr_m2dbiu=0x100, ack_a2m=01 with dat_a2m=0xCAFE, then IDLE.
REQ-036 req_m2a=11 held continuously, immediate acks -> grants alternate 0,1,0,1; no CPU acked twice in a row.
REQ-037 TIMEOUT=4, no downstream ack -> 4th BUSY cycle ack_a2m[g]=1, err_a2m[g]=1, dat_a2m=0; req_m2dbiu drops next cycle.
REQ-038 TIMEOUT=4, ack_dbiu2m in the 4th BUSY cycle -> normal ack, err_a2m=0.
REQ-039 rst_n pulsed low in BUSY -> outputs 0 immediately, no ack_a2m; after release with req_m2a=10 -> CPU 1 granted.
REQ-040 ack_dbiu2m pulsed while IDLE -> no ack_a2m, FSM remains IDLE.
